// File: rtl/somador_pkg.sv
// Shared types and elaboration helpers for the serial adder.
package somador_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int steps(input int width, input int digit);
        return width / digit;
    endfunction

    // One extra count so the counter can hold STEPS after the final increment.
    function automatic int cnt_width(input int n_steps);
        return $clog2(n_steps + 1);
    endfunction

endpackage

// File: rtl/somador_completo_tt.sv
// Single-bit full adder written as an explicit truth table on {a, b, cin}.
module somador_completo_tt (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic s_o,
    output logic cout_o
);

    always_comb begin
        // NOTE: default assignment before the case keeps this purely combinational (no latch).
        {cout_o, s_o} = 2'b00;
        case ({a_i, b_i, cin_i})
            3'b000: {cout_o, s_o} = 2'b00;
            3'b001: {cout_o, s_o} = 2'b01;
            3'b010: {cout_o, s_o} = 2'b01;
            3'b011: {cout_o, s_o} = 2'b10;
            3'b100: {cout_o, s_o} = 2'b01;
            3'b101: {cout_o, s_o} = 2'b10;
            3'b110: {cout_o, s_o} = 2'b10;
            3'b111: {cout_o, s_o} = 2'b11;
        endcase
    end

endmodule

// File: rtl/somador_serial.sv
// Multi-cycle adder: DIGIT bits of A+B+Cin per clock, start/done handshake.
// Optional macro SOMADOR_SERIAL_OVF_EN adds a registered two's-complement overflow output.
module somador_serial
    import somador_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SOMADOR_SERIAL_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int STEPS = steps(WIDTH, DIGIT);
    localparam int CNT_W = cnt_width(STEPS);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    generate
        if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
            $error("somador_serial: DIGIT must be >=1 and divide WIDTH exactly");
        end
    endgenerate

    state_t             state_q;
    logic [WIDTH-1:0]   opa_q;
    logic [WIDTH-1:0]   opb_q;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;

    logic [DIGIT:0]     chain;
    logic [DIGIT-1:0]   slice_s;
    logic [WIDTH-1:0]   opa_d;
    logic [WIDTH-1:0]   opb_d;
    logic               carry_d;

    // Ripple slice over the DIGIT low bits of both operands.
    assign chain[0] = carry_q;
    for (genvar i = 0; i < DIGIT; i++) begin : g_slice
        somador_completo_tt u_fa (
            .a_i    (opa_q[i]),
            .b_i    (opb_q[i]),
            .cin_i  (chain[i]),
            .s_o    (slice_s[i]),
            .cout_o (chain[i+1])
        );
    end

    // Operand A register doubles as the result register: slice bits enter at the MSB end
    // as consumed operand bits leave at the LSB end.
    generate
        if (DIGIT == WIDTH) begin : g_one_step
            assign opa_d = slice_s;
        end else begin : g_multi_step
            assign opa_d = {slice_s, opa_q[WIDTH-1:DIGIT]};
        end
    endgenerate

    assign opb_d   = opb_q >> DIGIT;
    assign carry_d = chain[DIGIT];

`ifdef SOMADOR_SERIAL_OVF_EN
    logic ovf_q;
    assign ovf = ovf_q;
`endif

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SOMADOR_SERIAL_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        opa_q   <= a;
                        opb_q   <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    opa_q   <= opa_d;
                    opb_q   <= opb_d;
                    carry_q <= carry_d;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_STEP) begin
                        sum_q   <= opa_d;
                        cout_q  <= carry_d;
`ifdef SOMADOR_SERIAL_OVF_EN
                        ovf_q   <= chain[DIGIT-1] ^ chain[DIGIT];
`endif
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_somador_serial.sv
// Self-checking bench for somador_serial: one DIGIT=1 and one DIGIT=4 instance, scoreboard queue.
`timescale 1ns/1ps
module tb_somador_serial;

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start1 = 1'b0;
    logic       start4 = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       cin = 1'b0;

    logic       busy1, done1, cout1;
    logic [7:0] sum1;
    logic       busy4, done4, cout4;
    logic [7:0] sum4;
`ifdef SOMADOR_SERIAL_OVF_EN
    logic       ovf1, ovf4;
`endif

    int errors = 0;
    int checks = 0;
    exp_t exp_q[$];
    logic [8:0] prev[2];

    always #5 clk = ~clk;

    somador_serial #(.WIDTH(8), .DIGIT(1)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
`ifdef SOMADOR_SERIAL_OVF_EN
        ,
        .ovf   (ovf1)
`endif
    );

    somador_serial #(.WIDTH(8), .DIGIT(4)) dut4 (
        .clk   (clk),
        .rst   (rst),
        .start (start4),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
        .cout  (cout4)
`ifdef SOMADOR_SERIAL_OVF_EN
        ,
        .ovf   (ovf4)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one operation on the selected instance and follow it to completion.
    task automatic run_op(input bit sel, input logic [7:0] av, input logic [7:0] bv,
                          input logic cv, input bit reassert);
        exp_t       e;
        logic [8:0] full;
        int         n_steps, cyc, busy_cnt;
        logic       d, bz;
        n_steps = sel ? 2 : 8;
        full    = 9'(av) + 9'(bv) + 9'(cv);
        e.sum   = full[7:0];
        e.cout  = full[8];
        e.ovf   = (av[7] == bv[7]) && (full[7] != av[7]);
        a = av; b = bv; cin = cv;
        if (sel) start4 = 1'b1; else start1 = 1'b1;
        exp_q.push_back(e);
        step();
        start1 = 1'b0; start4 = 1'b0;
        a = ~av; b = 8'($urandom); cin = ~cv;
        check("held_result", sel ? {cout4, sum4} : {cout1, sum1}, prev[sel]);
        cyc = 0; busy_cnt = 0;
        d = sel ? done4 : done1;
        while (!d && cyc < 40) begin
            bz = sel ? busy4 : busy1;
            if (bz) busy_cnt++;
            if (reassert && cyc == 2) begin start1 = 1'b1; a = 8'hF0; b = 8'h0F; end
            if (reassert && cyc == 4) start1 = 1'b0;
            step();
            cyc++;
            d = sel ? done4 : done1;
        end
        check("done_seen", d, 1'b1);
        check("latency", cyc, n_steps);
        check("busy_cycles", busy_cnt, n_steps);
        check("busy_in_done", sel ? busy4 : busy1, 1'b0);
        if (exp_q.size() == 0) begin
            check("scoreboard_nonempty", 0, 1);
        end else begin
            e = exp_q.pop_front();
            check("sum", sel ? sum4 : sum1, e.sum);
            check("cout", sel ? cout4 : cout1, e.cout);
`ifdef SOMADOR_SERIAL_OVF_EN
            check("ovf", sel ? ovf4 : ovf1, e.ovf);
`endif
            prev[sel] = {e.cout, e.sum};
        end
        step();
        check("done_one_pulse", sel ? done4 : done1, 1'b0);
    endtask

    initial begin
        int n_done;
        prev[0] = 9'h000;
        prev[1] = 9'h000;

        // Reset with start asserted: reset must win.
        start1 = 1'b1; start4 = 1'b1; a = 8'h55; b = 8'h55;
        step(); step();
        start1 = 1'b0; start4 = 1'b0;
        rst = 1'b0;
        step();
        check("rst_busy1", busy1, 1'b0);
        check("rst_done1", done1, 1'b0);
        check("rst_sum1", sum1, 8'h00);
        check("rst_cout1", cout1, 1'b0);
        check("rst_busy4", busy4, 1'b0);
        check("rst_sum4", sum4, 8'h00);
`ifdef SOMADOR_SERIAL_OVF_EN
        check("rst_ovf1", ovf1, 1'b0);
`endif

        run_op(1'b0, 8'h0F, 8'h01, 1'b0, 1'b0);
        run_op(1'b0, 8'hFF, 8'h01, 1'b0, 1'b0);
        run_op(1'b0, 8'hFF, 8'hFF, 1'b1, 1'b0);
        run_op(1'b1, 8'h9A, 8'h77, 1'b0, 1'b0);
        run_op(1'b1, 8'h12, 8'h34, 1'b1, 1'b0);

        // start re-asserted during RUN must be ignored.
        run_op(1'b0, 8'h01, 8'h01, 1'b0, 1'b1);
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            if (done1) n_done++;
            step();
        end
        check("no_extra_done", n_done, 0);
        check("idle_after_ignore", busy1, 1'b0);

        // Reset in the middle of an operation discards it.
        a = 8'hAA; b = 8'h33; cin = 1'b1; start1 = 1'b1;
        step();
        start1 = 1'b0;
        step(); step(); step();
        check("midop_busy", busy1, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_busy", busy1, 1'b0);
        check("midrst_done", done1, 1'b0);
        check("midrst_sum", sum1, 8'h00);
        check("midrst_cout", cout1, 1'b0);
        prev[0] = 9'h000;
        prev[1] = 9'h000;
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            if (done1) n_done++;
            step();
        end
        check("midrst_no_done", n_done, 0);
        run_op(1'b0, 8'h3C, 8'h55, 1'b1, 1'b0);

        // Signed-overflow boundaries (ovf compared only when the port exists).
        run_op(1'b0, 8'h7F, 8'h01, 1'b0, 1'b0);
        run_op(1'b0, 8'hFF, 8'h01, 1'b0, 1'b0);
        run_op(1'b0, 8'h80, 8'h80, 1'b0, 1'b0);
        run_op(1'b1, 8'h7F, 8'h01, 1'b0, 1'b0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
